// File: rtl/pattern_serializer_pkg.sv
// Shared types and constants for the serial pattern path.
// Imported by the serializer, its interface and its bench.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [4:0] PAT_10011 = 5'b10011;

endpackage

// File: rtl/pattern_serializer_if.sv
// Pattern word handshake into the serializer.
// Producer drives valid/data/rpt, serializer drives ready.
interface pattern_serializer_if #(
    parameter int DATA_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        in_rpt;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_rpt,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_rpt,
        output in_ready
    );
endinterface

// File: rtl/pattern_serializer_bit_tick_gen.sv
// Free-running clock divider producing a one-clk bit-rate strobe.
// Shared by the slower serial blocks.
module bit_tick_gen #(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 28
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // count 0..TICK_DIV-1 and wrap, never realigned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pattern_serializer.sv
// Parallel pattern word to MSB-first serial line with repeat
// and a trailing low gap, paced by a divided bit tick.
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int DATA_W   = 5,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 28,
    parameter int GAP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_serializer_if.slave  in_if,
    output logic                 w,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 bit_tick
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_BITS + 1);

    state_t            state, state_n;
    logic              w_n, frame_done_n;
    logic [DATA_W-1:0] shadow, shadow_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [3:0]        rep, rep_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;

    bit_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (bit_tick)
    );

    assign in_if.in_ready = (state == IDLE);
    assign busy           = (state == SHIFT) || (state == GAP);

    // next state and datapath; w only moves on tick edges
    always_comb begin
        state_n      = state;
        w_n          = w;
        frame_done_n = 1'b0;
        shadow_n     = shadow;
        shift_n      = shift;
        rep_n        = rep;
        bit_cnt_n    = bit_cnt;
        gap_cnt_n    = gap_cnt;
        unique case (state)
            IDLE: begin
                if (in_if.in_valid) begin
                    shadow_n = in_if.in_data;
                    shift_n  = in_if.in_data;
                    rep_n    = in_if.in_rpt;
                    state_n  = ARMED;
                end
            end
            ARMED: begin
                if (bit_tick) begin
                    w_n       = shift[DATA_W-1];
                    shift_n   = {shift[DATA_W-2:0], 1'b0};
                    bit_cnt_n = BIT_W'(1);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt != BIT_W'(DATA_W)) begin
                        w_n       = shift[DATA_W-1];
                        shift_n   = {shift[DATA_W-2:0], 1'b0};
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end else if (rep != 4'd0) begin
                        rep_n     = rep - 4'd1;
                        w_n       = shadow[DATA_W-1];
                        shift_n   = {shadow[DATA_W-2:0], 1'b0};
                        bit_cnt_n = BIT_W'(1);
                    end else begin
                        w_n       = 1'b0;
                        bit_cnt_n = '0;
                        gap_cnt_n = GAP_W'(1);
                        state_n   = GAP;
                    end
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt == GAP_W'(GAP_BITS)) begin
                        gap_cnt_n    = '0;
                        frame_done_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            w          <= 1'b0;
            frame_done <= 1'b0;
            shadow     <= '0;
            shift      <= '0;
            rep        <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            w          <= w_n;
            frame_done <= frame_done_n;
            shadow     <= shadow_n;
            shift      <= shift_n;
            rep        <= rep_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
        end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer at TICK_DIV=1 and 4,
// with a 10011 sequence detector fed from the serial line.
module tb_pattern_serializer;
    import pattern_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   sel   = 1'b0;

    logic w1, busy1, fd1, bt1;
    logic w4, busy4, fd4, bt4;
    logic ws, bs, fs, ts, rs;

    pattern_serializer_if #(.DATA_W(5)) if1 ();
    pattern_serializer_if #(.DATA_W(5)) if4 ();

    pattern_serializer #(
        .DATA_W(5), .TICK_DIV(1), .CNT_W(28), .GAP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .in_if(if1),
        .w(w1), .busy(busy1), .frame_done(fd1), .bit_tick(bt1)
    );

    pattern_serializer #(
        .DATA_W(5), .TICK_DIV(4), .CNT_W(28), .GAP_BITS(2)
    ) dut4 (
        .clk(clk), .rst(rst), .in_if(if4),
        .w(w4), .busy(busy4), .frame_done(fd4), .bit_tick(bt4)
    );

    assign ws = sel ? w4 : w1;
    assign bs = sel ? busy4 : busy1;
    assign fs = sel ? fd4 : fd1;
    assign ts = sel ? bt4 : bt1;
    assign rs = sel ? if4.in_ready : if1.in_ready;

    always #5 clk = ~clk;

    // reference detector, clocked on the bit tick
    logic [3:0] hist = 4'd0;
    int         zcnt = 0;
    int         fdcnt = 0;
    always @(posedge clk) begin
        if (bt1) begin
            hist <= {hist[2:0], w1};
            if ({hist, w1} == PAT_10011) zcnt <= zcnt + 1;
        end
        if (fd1) fdcnt <= fdcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] d,
                       input logic [3:0] r);
        if (sel) begin
            if4.in_valid = v; if4.in_data = d; if4.in_rpt = r;
        end else begin
            if1.in_valid = v; if1.in_data = d; if1.in_rpt = r;
        end
    endtask

    task automatic send(input string tag, input logic [4:0] d,
                        input logic [3:0] r);
        int n = 0;
        while (!rs && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_rdy_wait"}, 32'(rs), 32'd1);
        drv(1'b1, d, r);
        step();
        drv(1'b0, 5'd0, 4'd0);
        chk({tag, "_armed_rdy"}, 32'(rs), 32'd0);
    endtask

    // wait for first bit, then check every clk of the frame
    task automatic run(input string tag, input logic [79:0] e,
                       input int n, input bit noise, output int lat);
        int td = sel ? 4 : 1;
        lat = 0;
        while (!bs && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_busy_wait"}, 32'(bs), 32'd1);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < td; k++) begin
                chk($sformatf("%s_w%0d_%0d", tag, j, k),
                    32'(ws), 32'(e[n-1-j]));
                if (k == td - 1)
                    chk($sformatf("%s_tick%0d", tag, j), 32'(ts), 32'd1);
                if (noise && j < n - 1) begin
                    drv(1'b1, 5'($urandom), 4'($urandom));
                    chk($sformatf("%s_rdy%0d_%0d", tag, j, k),
                        32'(rs), 32'd0);
                end else if (noise) begin
                    drv(1'b0, 5'd0, 4'd0);
                end
                step();
            end
        end
        chk({tag, "_done"}, 32'(fs), 32'd1);
        chk({tag, "_done_rdy"}, 32'(rs), 32'd1);
        chk({tag, "_done_w"}, 32'(ws), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(fs), 32'd0);
    endtask

    initial begin
        int lat;
        int z0;
        int f0;
        int n;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_rpt = '0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_rpt = '0;
        step();
        step();
        chk("rst_w", 32'(w1), 32'd0);
        chk("rst_rdy", 32'(if1.in_ready), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(fd1), 32'd0);
        chk("rst_w4", 32'(w4), 32'd0);
        rst = 1'b1;
        step();

        // T1 single frame
        sel = 1'b0;
        send("t1", PAT_10011, 4'd0);
        chk("t1_armed_busy", 32'(busy1), 32'd0);
        run("t1", 80'(7'b1001100), 7, 1'b0, lat);
        chk("t1_lat", 32'(lat), 32'd1);

        // T2 one repeat, no gap between copies
        send("t2", PAT_10011, 4'd1);
        run("t2", 80'(12'b100111001100), 12, 1'b0, lat);
        chk("t2_lat", 32'(lat), 32'd1);

        // T4 offers during the frame are ignored
        send("t4", PAT_10011, 4'd0);
        run("t4", 80'(7'b1001100), 7, 1'b1, lat);
        chk("t4_idle_busy", 32'(busy1), 32'd0);
        chk("t4_idle_rdy", 32'(if1.in_ready), 32'd1);

        // T5 reset during the third bit
        send("t5", PAT_10011, 4'd0);
        n = 0;
        while (!busy1 && n < 40) begin
            step();
            n++;
        end
        chk("t5_busy_wait", 32'(busy1), 32'd1);
        step();
        step();
        chk("t5_bit3", 32'(w1), 32'd0);
        chk("t5_bit3_busy", 32'(busy1), 32'd1);
        f0 = fdcnt;
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_w", 32'(w1), 32'd0);
        chk("t5_rst_busy", 32'(busy1), 32'd0);
        chk("t5_rst_rdy", 32'(if1.in_ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t5_no_done", 32'(fdcnt - f0), 32'd0);
        send("t5b", 5'b11010, 4'd0);
        run("t5b", 80'(7'b1101000), 7, 1'b0, lat);

        // T3 divided rate, accept on a tick edge
        sel = 1'b1;
        n = 0;
        while (!bt4 && n < 8) begin
            step();
            n++;
        end
        chk("t3_tick_wait", 32'(bt4), 32'd1);
        drv(1'b1, PAT_10011, 4'd0);
        step();
        drv(1'b0, 5'd0, 4'd0);
        chk("t3_armed_busy", 32'(busy4), 32'd0);
        run("t3", 80'(7'b1001100), 7, 1'b0, lat);
        chk("t3_lat", 32'(lat), 32'd4);

        // T6 loopback into the detector
        sel = 1'b0;
        z0 = zcnt;
        send("t6", PAT_10011, 4'd2);
        run("t6", 80'(17'b10011100111001100), 17, 1'b0, lat);
        step();
        chk("t6_z", 32'(zcnt - z0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
